// File: rtl/aes_pkg.sv
// Constants and state encoding shared by the AES-128 forward and inverse round controllers.
package aes_pkg;

  localparam int AES_NR  = 10;
  localparam int AES_KIW = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_KEY = 3'd1,
    INIT     = 3'd2,
    SUB      = 3'd3,
    LATCH    = 3'd4,
    DONE     = 3'd5
  } inv_state_e;

endpackage

// File: rtl/aes_inv_controller.sv
// AES-128 inverse cipher sequencer: walks round keys NR..0 and drives the inverse
// datapath controls (input mux, InvSubBytes BRAM wait, InvMixColumns bypass, state write).
module aes_inv_controller
  import aes_pkg::*;
#(
  parameter int NR       = AES_NR,
  parameter int KIW      = AES_KIW,
  parameter int SBOX_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           key_ready,
  output logic [KIW-1:0] key_idx,
  output logic           state_sel,
  output logic           sbox_en,
  output logic           inv_mix_en,
  output logic           state_we,
  output logic           busy,
  output logic           done
);

  inv_state_e     state_q, state_d;
  logic [KIW-1:0] r_q, r_d;
  logic [1:0]     wait_q, wait_d;

  logic [KIW-1:0] key_idx_q, key_idx_d;
  logic           state_sel_q, state_sel_d;
  logic           sbox_en_q, sbox_en_d;
  logic           inv_mix_en_q, inv_mix_en_d;
  logic           state_we_q, state_we_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE:     if (start) state_d = key_ready ? INIT : WAIT_KEY;
      WAIT_KEY: if (key_ready) state_d = INIT;
      INIT: begin
        state_d = SUB;
        r_d     = KIW'(NR - 1);
        wait_d  = '0;
      end
      SUB: begin
        if (wait_q == 2'(SBOX_LAT - 1)) state_d = LATCH;
        else                            wait_d  = wait_q + 2'd1;
      end
      LATCH: begin
        // r==0 is the final round; the counter is never decremented past it
        if (r_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = SUB;
          r_d     = r_q - KIW'(1);
          wait_d  = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state they describe.
  always_comb begin
    key_idx_d    = '0;
    state_sel_d  = 1'b0;
    sbox_en_d    = 1'b0;
    inv_mix_en_d = 1'b0;
    state_we_d   = 1'b0;
    done_d       = 1'b0;
    case (state_d)
      INIT: begin
        key_idx_d  = KIW'(NR);
        state_we_d = 1'b1;
      end
      SUB: begin
        key_idx_d   = r_d;
        sbox_en_d   = 1'b1;
        state_sel_d = 1'b1;
      end
      LATCH: begin
        key_idx_d    = r_d;
        state_sel_d  = 1'b1;
        state_we_d   = 1'b1;
        inv_mix_en_d = (r_d != '0);
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      r_q          <= '0;
      wait_q       <= '0;
      key_idx_q    <= '0;
      state_sel_q  <= 1'b0;
      sbox_en_q    <= 1'b0;
      inv_mix_en_q <= 1'b0;
      state_we_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      wait_q       <= wait_d;
      key_idx_q    <= key_idx_d;
      state_sel_q  <= state_sel_d;
      sbox_en_q    <= sbox_en_d;
      inv_mix_en_q <= inv_mix_en_d;
      state_we_q   <= state_we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign key_idx    = key_idx_q;
  assign state_sel  = state_sel_q;
  assign sbox_en    = sbox_en_q;
  assign inv_mix_en = inv_mix_en_q;
  assign state_we   = state_we_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_aes_inv_controller.sv
// Bench for aes_inv_controller: cycle traces against a round-schedule model, plus
// a reference inverse datapath driven by the controls to decrypt the FIPS-197 vector.
module tb_aes_inv_controller;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst, start, key_ready;
  logic [3:0] key_idx1, key_idx2;
  logic sel1, sb1, mix1, we1, busy1, done1;
  logic sel2, sb2, mix2, we2, busy2, done2;
  logic [9:0] o1, o2;

  always #5 clk = ~clk;

  aes_inv_controller #(.NR(10), .KIW(4), .SBOX_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .key_ready(key_ready),
    .key_idx(key_idx1), .state_sel(sel1), .sbox_en(sb1), .inv_mix_en(mix1),
    .state_we(we1), .busy(busy1), .done(done1));

  aes_inv_controller #(.NR(10), .KIW(4), .SBOX_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .key_ready(key_ready),
    .key_idx(key_idx2), .state_sel(sel2), .sbox_en(sb2), .inv_mix_en(mix2),
    .state_we(we2), .busy(busy2), .done(done2));

  assign o1 = {key_idx1, sel1, sb1, mix1, we1, busy1, done1};
  assign o2 = {key_idx2, sel2, sb2, mix2, we2, busy2, done2};

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- AES reference arithmetic ----------------
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk    [11];
  logic [127:0] dp;
  logic         dp_clr = 1'b0;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;

  function automatic logic [7:0] xt(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] b, int n);
    logic [7:0] v = b;
    for (int i = 0; i < n; i++) v = {v[6:0], v[7]};
    return v;
  endfunction

  function automatic logic [7:0] gb(logic [127:0] s, int i);
    return s[127-8*i -: 8];
  endfunction

  // Textbook inverse round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
  function automatic logic [127:0] inv_round(logic [127:0] s, logic [127:0] k, logic mix);
    logic [127:0] t, u;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = isbox[gb(s, 4*((c - r + 4) % 4) + r)];
    t = t ^ k;
    if (!mix) return t;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(t, 4*c); a1 = gb(t, 4*c+1); a2 = gb(t, 4*c+2); a3 = gb(t, 4*c+3);
      u[127-8*(4*c)   -: 8] = gm(a0,8'h0e) ^ gm(a1,8'h0b) ^ gm(a2,8'h0d) ^ gm(a3,8'h09);
      u[127-8*(4*c+1) -: 8] = gm(a0,8'h09) ^ gm(a1,8'h0e) ^ gm(a2,8'h0b) ^ gm(a3,8'h0d);
      u[127-8*(4*c+2) -: 8] = gm(a0,8'h0d) ^ gm(a1,8'h09) ^ gm(a2,8'h0e) ^ gm(a3,8'h0b);
      u[127-8*(4*c+3) -: 8] = gm(a0,8'h0b) ^ gm(a1,8'h0d) ^ gm(a2,8'h09) ^ gm(a3,8'h0e);
    end
    return u;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0] rc;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv,1) ^ rotl(inv,2) ^ rotl(inv,3) ^ rotl(inv,4) ^ 8'h63;
      sbox[x] = s;
      isbox[s] = 8'(x);
    end
    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 11; i++) rk[i] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
  endtask

  // Reference datapath slaved to dut1's controls.
  always @(posedge clk) begin
    if (dp_clr) dp <= '0;
    else if (we1) begin
      if (!sel1) dp <= CT ^ rk[int'(key_idx1)];
      else       dp <= inv_round(dp, rk[int'(key_idx1)], mix1);
    end
  end

  // ---------------- round-schedule model ----------------
  // Each entry: {care mask[9:0], value[9:0]} over {key_idx, sel, sbox, mix, we, busy, done}.
  typedef logic [19:0] ev_t;
  typedef ev_t evq_t[$];

  function automatic ev_t mk(int key, bit sel, bit sb, bit mix, bit we, bit bsy, bit dn,
                             bit selcare);
    logic [9:0] v, m;
    v = {4'(key), sel, sb, mix, we, bsy, dn};
    m = 10'h3ff;
    if (!selcare) m[5] = 1'b0;
    return {m, v};
  endfunction

  localparam ev_t IDLE_EV = {10'h3ff, 10'h000};

  // d WAIT_KEY cycles, INIT, then per round L lookup cycles plus one latch, then DONE.
  function automatic evq_t build_trace(int L, int d);
    evq_t q;
    q = {};
    for (int i = 0; i < d; i++) q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1));
    q.push_back(mk(10, 0, 0, 0, 1, 1, 0, 1));
    for (int k = 9; k >= 0; k--) begin
      for (int j = 0; j < L; j++) q.push_back(mk(k, 0, 1, 0, 0, 1, 0, 0));
      q.push_back(mk(k, 1, 0, (k != 0), 1, 1, 0, 1));
    end
    q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1));
    return q;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; key_ready = 1'b1;
    step(); step();
    n_cmp++;
    if (o1 !== 10'h000) begin n_err++; $display("FAIL reset_l1 got=%h exp=000", o1); end
    n_cmp++;
    if (o2 !== 10'h000) begin n_err++; $display("FAIL reset_l2 got=%h exp=000", o2); end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_nominal();
    evq_t q;
    ev_t e;
    do_reset();
    dp_clr = 1'b1; step(); dp_clr = 1'b0;
    key_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    q = build_trace(1, 0);
    for (int c = 1; c <= 24; c++) begin
      e = (c <= q.size()) ? q[c-1] : IDLE_EV;
      n_cmp++;
      if ((o1 & e[19:10]) !== (e[9:0] & e[19:10])) begin
        n_err++; $display("FAIL nominal c=%0d got=%h exp=%h", c, o1, e[9:0]);
      end
      step();
    end
    n_cmp++;
    if (dp !== PT) begin n_err++; $display("FAIL plaintext got=%h exp=%h", dp, PT); end
  endtask

  task automatic test_key_wait();
    evq_t q;
    ev_t e;
    do_reset();
    key_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    q = build_trace(1, 5);
    for (int c = 1; c <= 28; c++) begin
      e = (c <= q.size()) ? q[c-1] : IDLE_EV;
      n_cmp++;
      if ((o1 & e[19:10]) !== (e[9:0] & e[19:10])) begin
        n_err++; $display("FAIL key_wait c=%0d got=%h exp=%h", c, o1, e[9:0]);
      end
      if (c == 5) key_ready = 1'b1;
      step();
    end
  endtask

  task automatic test_reset_mid();
    evq_t q;
    ev_t e;
    do_reset();
    key_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    q = build_trace(1, 0);
    for (int c = 1; c <= 11; c++) begin
      e = q[c-1];
      n_cmp++;
      if ((o1 & e[19:10]) !== (e[9:0] & e[19:10])) begin
        n_err++; $display("FAIL rst_mid_pre c=%0d got=%h exp=%h", c, o1, e[9:0]);
      end
      if (c < 11) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (o1 !== 10'h000) begin n_err++; $display("FAIL rst_mid_l1 got=%h exp=000", o1); end
    n_cmp++;
    if (o2 !== 10'h000) begin n_err++; $display("FAIL rst_mid_l2 got=%h exp=000", o2); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      e = (c <= q.size()) ? q[c-1] : IDLE_EV;
      n_cmp++;
      if ((o1 & e[19:10]) !== (e[9:0] & e[19:10])) begin
        n_err++; $display("FAIL rst_mid_restart c=%0d got=%h exp=%h", c, o1, e[9:0]);
      end
      step();
    end
  endtask

  task automatic test_start_ignored();
    evq_t q;
    ev_t e;
    int dones = 0;
    do_reset();
    key_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    q = build_trace(1, 0);
    for (int c = 1; c <= 30; c++) begin
      e = (c <= q.size()) ? q[c-1] : IDLE_EV;
      n_cmp++;
      if ((o1 & e[19:10]) !== (e[9:0] & e[19:10])) begin
        n_err++; $display("FAIL start_ignored c=%0d got=%h exp=%h", c, o1, e[9:0]);
      end
      if (done1 === 1'b1) dones++;
      start = (c == 8 || c == 22);
      step();
      start = 1'b0;
    end
    n_cmp++;
    if (dones != 1) begin n_err++; $display("FAIL done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_sbox_lat2();
    evq_t q;
    ev_t e;
    int sb_cycles = 0;
    do_reset();
    key_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    q = build_trace(2, 0);
    for (int c = 1; c <= 33; c++) begin
      e = (c <= q.size()) ? q[c-1] : IDLE_EV;
      n_cmp++;
      if ((o2 & e[19:10]) !== (e[9:0] & e[19:10])) begin
        n_err++; $display("FAIL lat2 c=%0d got=%h exp=%h", c, o2, e[9:0]);
      end
      if (sb2 === 1'b1) sb_cycles++;
      step();
    end
    n_cmp++;
    if (sb_cycles != 20) begin n_err++; $display("FAIL lat2_sbox_cycles got=%0d exp=20", sb_cycles); end
  endtask

  task automatic test_continuous();
    evq_t q;
    ev_t e;
    int p;
    do_reset();
    key_ready = 1'b1; start = 1'b1;
    step();
    q = build_trace(1, 0);
    for (int c = 1; c <= 70; c++) begin
      p = (c - 1) % 23;
      e = (p < q.size()) ? q[p] : IDLE_EV;
      n_cmp++;
      if ((o1 & e[19:10]) !== (e[9:0] & e[19:10])) begin
        n_err++; $display("FAIL continuous c=%0d got=%h exp=%h", c, o1, e[9:0]);
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_random();
    evq_t q1, q2;
    ev_t e1, e2;
    int d, gap;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      dp_clr = 1'b1; step(); dp_clr = 1'b0;
      d = $urandom_range(0, 4);
      gap = $urandom_range(0, 3);
      key_ready = (d == 0);
      for (int g = 0; g < gap; g++) begin
        n_cmp++;
        if (o1 !== 10'h000) begin n_err++; $display("FAIL rand_idle it=%0d got=%h", it, o1); end
        step();
      end
      start = 1'b1;
      step();
      q1 = build_trace(1, d);
      q2 = build_trace(2, d);
      for (int c = 1; c <= d + 33; c++) begin
        e1 = (c <= q1.size()) ? q1[c-1] : IDLE_EV;
        e2 = (c <= q2.size()) ? q2[c-1] : IDLE_EV;
        n_cmp++;
        if ((o1 & e1[19:10]) !== (e1[9:0] & e1[19:10])) begin
          n_err++; $display("FAIL rand_l1 it=%0d d=%0d c=%0d got=%h exp=%h", it, d, c, o1, e1[9:0]);
        end
        n_cmp++;
        if ((o2 & e2[19:10]) !== (e2[9:0] & e2[19:10])) begin
          n_err++; $display("FAIL rand_l2 it=%0d d=%0d c=%0d got=%h exp=%h", it, d, c, o2, e2[9:0]);
        end
        // start noise is harmless while both controllers are busy
        start = (c <= d + 22) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (c == d && d > 0) key_ready = 1'b1;
        else if (c > d)      key_ready = 1'($urandom_range(0, 1));
        step();
      end
      start = 1'b0;
      n_cmp++;
      if (dp !== PT) begin n_err++; $display("FAIL rand_plaintext it=%0d got=%h exp=%h", it, dp, PT); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key_ready = 1'b0;
    build_tables();
    test_reset();
    test_nominal();
    test_key_wait();
    test_reset_mid();
    test_start_ignored();
    test_sbox_lat2();
    test_continuous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
